// File: rtl/ram_arb_pkg.sv
// ram_arb_pkg: shared types for the RAM port A arbiter.
//   owner_t     - arbiter ownership state (IDLE / OWN0 / OWN1)
//   req_beat_t  - one requester beat (we, last, addr, wdata), sized to the
//                 default RAM geometry used by ram_port_arb
//   NUM_REQ     - number of requesters sharing port A
package ram_arb_pkg;

    localparam int NUM_REQ    = 2;
    localparam int RAM_DATA_W = 32;
    localparam int RAM_ADDR_W = 10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } owner_t;

    typedef struct packed {
        logic                  we;
        logic                  last;
        logic [RAM_ADDR_W-1:0] addr;
        logic [RAM_DATA_W-1:0] wdata;
    } req_beat_t;

endpackage

// File: rtl/rr_pick.sv
// rr_pick: 2-way round-robin priority picker, purely combinational.
//   req  [1:0] in  - request vector
//   prio       in  - requester that wins when both request
//   gnt  [1:0] out - one-hot (or zero) grant
module rr_pick
    import ram_arb_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  logic               prio,
    output logic [NUM_REQ-1:0] gnt
);

    assign gnt[0] = req[0] & (~req[1] | ~prio);
    assign gnt[1] = req[1] & (~req[0] |  prio);

endmodule

// File: rtl/ram_port_arb.sv
// ram_port_arb: round-robin arbiter for port A of the waveform RAM.
// Requester 0 = table loader, requester 1 = DDS/debug readback.
// An owner keeps the port for a burst until it signals last, drops its
// request, or has taken MAX_BURST beats while the other side waits.
//
// Ports:
//   clka, rst_n                 clock (also RAM clock), async active-low reset
//   reqN/weN/lastN/addrN/wdataN requester beat inputs
//   gntN                        combinational beat accept
//   rvalidN/rdataN              read return, one cycle after an accepted read
//   ram_wea/ram_addra/ram_dina  RAM port A drive
//   ram_douta                   RAM port A read data
// Optional (macro RAM_PORT_ARB_STATS_EN):
//   grant_cnt0/1, stall_cnt     saturating statistics counters
module ram_port_arb
    import ram_arb_pkg::*;
#(
    parameter int DATA_WIDTH = RAM_DATA_W,
    parameter int ADDR_WIDTH = RAM_ADDR_W,
    parameter int MAX_BURST  = 16,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clka,
    input  logic                  rst_n,
    input  logic                  req0,
    input  logic                  req1,
    input  logic                  we0,
    input  logic                  we1,
    input  logic                  last0,
    input  logic                  last1,
    input  logic [ADDR_WIDTH-1:0] addr0,
    input  logic [ADDR_WIDTH-1:0] addr1,
    input  logic [DATA_WIDTH-1:0] wdata0,
    input  logic [DATA_WIDTH-1:0] wdata1,
    output logic                  gnt0,
    output logic                  gnt1,
    output logic                  rvalid0,
    output logic                  rvalid1,
    output logic [DATA_WIDTH-1:0] rdata0,
    output logic [DATA_WIDTH-1:0] rdata1,
    output logic                  ram_wea,
    output logic [ADDR_WIDTH-1:0] ram_addra,
    output logic [DATA_WIDTH-1:0] ram_dina,
`ifdef RAM_PORT_ARB_STATS_EN
    output logic [CNT_WIDTH-1:0]  grant_cnt0,
    output logic [CNT_WIDTH-1:0]  grant_cnt1,
    output logic [CNT_WIDTH-1:0]  stall_cnt,
`endif
    input  logic [DATA_WIDTH-1:0] ram_douta
);

    localparam int BCNT_W = $clog2(MAX_BURST) + 1;
    localparam logic [BCNT_W-1:0] BURST_TOP = BCNT_W'(MAX_BURST - 1);

    owner_t            owner_q, owner_d;
    logic              rr_q, rr_d;
    logic [BCNT_W-1:0] bcnt_q, bcnt_d;

    logic [NUM_REQ-1:0] req_v, idle_gnt, gnt_v, hand_req, hand_gnt;
    req_beat_t          beat0, beat1, beat_sel;
    logic               acc, cur_x, other_req, eob;
    owner_t             hand_owner;

    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] dina_q;
    logic                  rvalid0_q, rvalid1_q;

    assign req_v = {req1, req0};
    assign beat0 = '{we: we0, last: last0, addr: addr0, wdata: wdata0};
    assign beat1 = '{we: we1, last: last1, addr: addr1, wdata: wdata1};

    // Fresh arbitration when nobody owns the port.
    rr_pick u_idle_pick (
        .req  (req_v),
        .prio (rr_q),
        .gnt  (idle_gnt)
    );

    // Handover: only the non-current requester may take the port next.
    assign hand_req = cur_x ? {1'b0, req0} : {req1, 1'b0};

    rr_pick u_hand_pick (
        .req  (hand_req),
        .prio (~cur_x),
        .gnt  (hand_gnt)
    );

    assign hand_owner = hand_gnt[0] ? OWN0 : (hand_gnt[1] ? OWN1 : IDLE);

    // State register.
    always_ff @(posedge clka or negedge rst_n) begin
        if (!rst_n) begin
            owner_q <= IDLE;
            rr_q    <= 1'b0;
            bcnt_q  <= '0;
        end else begin
            owner_q <= owner_d;
            rr_q    <= rr_d;
            bcnt_q  <= bcnt_d;
        end
    end

    // Output decode: grants. Gated by reset so nothing is accepted while held.
    always_comb begin
        gnt_v = '0;
        case (owner_q)
            IDLE:    gnt_v = idle_gnt;
            OWN0:    gnt_v = {1'b0, req0};
            OWN1:    gnt_v = {req1, 1'b0};
            default: gnt_v = '0;
        endcase
        if (!rst_n) gnt_v = '0;
    end

    assign gnt0 = gnt_v[0];
    assign gnt1 = gnt_v[1];
    assign acc  = |gnt_v;

    // Requester of interest: the granted one on a beat, else the owner.
    assign cur_x     = acc ? gnt_v[1] : (owner_q == OWN1);
    assign beat_sel  = cur_x ? beat1 : beat0;
    assign other_req = cur_x ? req0 : req1;
    assign eob       = beat_sel.last | ((bcnt_q == BURST_TOP) & other_req);

    // Next-state logic.
    always_comb begin
        owner_d = owner_q;
        rr_d    = rr_q;
        bcnt_d  = bcnt_q;
        if (acc) begin
            if (eob) begin
                owner_d = hand_owner;
                rr_d    = ~cur_x;
                bcnt_d  = '0;
            end else begin
                owner_d = cur_x ? OWN1 : OWN0;
                // At BURST_TOP without eob the other side is idle: hold, so
                // an uncontended burst never terminates on count.
                if (bcnt_q != BURST_TOP) bcnt_d = bcnt_q + BCNT_W'(1);
            end
        end else if (owner_q != IDLE) begin
            // Owner dropped its request mid-burst.
            owner_d = hand_owner;
            rr_d    = ~cur_x;
            bcnt_d  = '0;
        end
    end

    // RAM drive: live beat when accepted, otherwise the last accepted values.
    always_ff @(posedge clka or negedge rst_n) begin
        if (!rst_n) begin
            addr_q <= '0;
            dina_q <= '0;
        end else if (acc) begin
            addr_q <= beat_sel.addr;
            dina_q <= beat_sel.wdata;
        end
    end

    assign ram_wea   = acc & beat_sel.we;
    assign ram_addra = acc ? beat_sel.addr  : addr_q;
    assign ram_dina  = acc ? beat_sel.wdata : dina_q;

    // Read return. Writes never flag rvalid: NO CHANGE mode leaves douta stale.
    always_ff @(posedge clka or negedge rst_n) begin
        if (!rst_n) begin
            rvalid0_q <= 1'b0;
            rvalid1_q <= 1'b0;
        end else begin
            rvalid0_q <= gnt_v[0] & ~we0;
            rvalid1_q <= gnt_v[1] & ~we1;
        end
    end

    assign rvalid0 = rvalid0_q;
    assign rvalid1 = rvalid1_q;
    assign rdata0  = ram_douta;
    assign rdata1  = ram_douta;

`ifdef RAM_PORT_ARB_STATS_EN
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    logic stall;
    assign stall = (req0 & ~gnt_v[0]) | (req1 & ~gnt_v[1]);

    always_ff @(posedge clka or negedge rst_n) begin
        if (!rst_n) begin
            grant_cnt0 <= '0;
            grant_cnt1 <= '0;
            stall_cnt  <= '0;
        end else begin
            if (gnt_v[0] && grant_cnt0 != CNT_MAX) grant_cnt0 <= grant_cnt0 + CNT_WIDTH'(1);
            if (gnt_v[1] && grant_cnt1 != CNT_MAX) grant_cnt1 <= grant_cnt1 + CNT_WIDTH'(1);
            if (stall    && stall_cnt  != CNT_MAX) stall_cnt  <= stall_cnt  + CNT_WIDTH'(1);
        end
    end
`endif

endmodule

// File: tb/tb_ram_port_arb.sv
// tb_ram_port_arb: directed bench for ram_port_arb with MAX_BURST = 4 and a
// NO CHANGE mode RAM model on port A. Statistics checks are compiled in only
// when RAM_PORT_ARB_STATS_EN is defined.
module tb_ram_port_arb;

    localparam int DW = 32;
    localparam int AW = 10;
    localparam int CW = 16;

    logic          clka = 1'b0;
    logic          rst_n = 1'b0;
    logic          req0 = 0, req1 = 0, we0 = 0, we1 = 0, last0 = 0, last1 = 0;
    logic [AW-1:0] addr0 = '0, addr1 = '0;
    logic [DW-1:0] wdata0 = '0, wdata1 = '0;
    logic          gnt0, gnt1, rvalid0, rvalid1, ram_wea;
    logic [DW-1:0] rdata0, rdata1, ram_dina;
    logic [AW-1:0] ram_addra;
    logic [DW-1:0] ram_douta = '0;
`ifdef RAM_PORT_ARB_STATS_EN
    logic [CW-1:0] grant_cnt0, grant_cnt1, stall_cnt;
`endif

    int n_chk = 0;
    int n_bad = 0;

    always #5 clka = ~clka;

    ram_port_arb #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MAX_BURST(4), .CNT_WIDTH(CW)) dut (
        .clka(clka), .rst_n(rst_n),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .last0(last0), .last1(last1), .addr0(addr0), .addr1(addr1),
        .wdata0(wdata0), .wdata1(wdata1),
        .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
        .rdata0(rdata0), .rdata1(rdata1),
        .ram_wea(ram_wea), .ram_addra(ram_addra), .ram_dina(ram_dina),
`ifdef RAM_PORT_ARB_STATS_EN
        .grant_cnt0(grant_cnt0), .grant_cnt1(grant_cnt1), .stall_cnt(stall_cnt),
`endif
        .ram_douta(ram_douta)
    );

    // NO CHANGE mode RAM: douta only updates on read cycles.
    logic [DW-1:0] mem [0:(1<<AW)-1];
    always @(posedge clka) begin
        if (ram_wea) mem[ram_addra] <= ram_dina;
        else         ram_douta      <= mem[ram_addra];
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h @%0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clka);
        #1;
    endtask

    task automatic drv(input logic r0, input logic w0, input logic l0, input logic [AW-1:0] a0,
                       input logic [DW-1:0] d0, input logic r1, input logic w1, input logic l1,
                       input logic [AW-1:0] a1, input logic [DW-1:0] d1);
        req0 = r0; we0 = w0; last0 = l0; addr0 = a0; wdata0 = d0;
        req1 = r1; we1 = w1; last1 = l1; addr1 = a1; wdata1 = d1;
    endtask

    task automatic idle();
        drv(0, 0, 0, '0, '0, 0, 0, 0, '0, '0);
    endtask

    task automatic do_reset();
        idle();
        rst_n = 1'b0;
        repeat (2) @(posedge clka);
        #1;
        rst_n = 1'b1;
    endtask

    function automatic logic [DW-1:0] pat(input int i);
        return 32'h1000_0000 + 32'(i * 3);
    endfunction

    initial begin
        do_reset();

        // Reset state
        #2;
        chk("rst_gnt0", gnt0, 0);
        chk("rst_gnt1", gnt1, 0);
        chk("rst_wea", ram_wea, 0);
        chk("rst_addr", ram_addra, 0);
        chk("rst_rv", {rvalid0, rvalid1}, 0);
        #1;

        // 1: write then read-back from the other requester
        drv(1, 1, 1, 10'd5, 32'hDEADBEEF, 0, 0, 0, '0, '0);
        #3;
        chk("s1_gnt0", gnt0, 1);
        chk("s1_wea", ram_wea, 1);
        chk("s1_addr", ram_addra, 5);
        chk("s1_dina", ram_dina, 32'hDEADBEEF);
        tick();
        drv(0, 0, 0, '0, '0, 1, 0, 1, 10'd5, '0);
        #3;
        chk("s1_gnt1", gnt1, 1);
        chk("s1_rd_wea", ram_wea, 0);
        chk("s1_rv_wr", rvalid0, 0);
        tick();
        idle();
        #3;
        chk("s1_rvalid1", rvalid1, 1);
        chk("s1_rdata1", rdata1, 32'hDEADBEEF);
        chk("s1_rvalid0", rvalid0, 0);
        chk("s1_hold_addr", ram_addra, 5);
        tick();

        // 2: continuous contention, bursts capped at 4 beats
        for (int i = 0; i < 16; i++) begin
            drv(1, 1, 0, 10'(100 + i), 32'(i), 1, 1, 0, 10'(200 + i), 32'(i));
            #3;
            chk($sformatf("s2_gnt0_%0d", i), gnt0, ((i / 4) % 2) == 0);
            chk($sformatf("s2_gnt1_%0d", i), gnt1, ((i / 4) % 2) == 1);
            tick();
        end
        idle();
        tick();

        // 3: simultaneous request from reset, rr = 0, handover without bubble
        do_reset();
        drv(1, 1, 1, 10'd50, 32'h55, 1, 1, 1, 10'd51, 32'h66);
        #3;
        chk("s3_gnt0", gnt0, 1);
        chk("s3_gnt1_lo", gnt1, 0);
        tick();
        drv(0, 0, 0, '0, '0, 1, 1, 1, 10'd51, 32'h66);
        #3;
        chk("s3_gnt1", gnt1, 1);
        chk("s3_addr", ram_addra, 51);
        tick();
        idle();
        tick();

        // 4: preload 0..7 via req0, then req1 reads them back-to-back
        for (int i = 0; i < 8; i++) begin
            drv(1, 1, i == 7, 10'(i), pat(i), 0, 0, 0, '0, '0);
            #3;
            chk($sformatf("s4_wr_gnt_%0d", i), gnt0, 1);
            tick();
        end
        for (int i = 0; i < 9; i++) begin
            if (i < 8) drv(0, 0, 0, '0, '0, 1, 0, i == 7, 10'(i), '0);
            else       idle();
            #3;
            if (i < 8) chk($sformatf("s4_gnt1_%0d", i), gnt1, 1);
            chk($sformatf("s4_rv_%0d", i), rvalid1, i > 0);
            if (i > 0) chk($sformatf("s4_rd_%0d", i - 1), rdata1, pat(i - 1));
            tick();
        end

        // 5: reset while OWN0 with a read in flight
        drv(1, 0, 0, 10'd2, '0, 0, 0, 0, '0, '0);
        #3;
        chk("s5_gnt0", gnt0, 1);
        tick();
        chk("s5_inflight", rvalid0, 1);
        drv(1, 0, 0, 10'd2, '0, 1, 0, 0, 10'd3, '0);
        rst_n = 1'b0;
        #1;
        chk("s5_rst_rv0", rvalid0, 0);
        chk("s5_rst_gnt0", gnt0, 0);
        chk("s5_rst_gnt1", gnt1, 0);
        #1;
        tick();
        rst_n = 1'b1;
        drv(0, 0, 0, '0, '0, 1, 0, 1, 10'd3, '0);
        #3;
        chk("s5_post_gnt1", gnt1, 1);
        tick();
        idle();
        #3;
        chk("s5_post_rv1", rvalid1, 1);
        chk("s5_post_rd1", rdata1, pat(3));
        tick();

`ifdef RAM_PORT_ARB_STATS_EN
        // 6: 20 contended cycles -> 20 grants total and 20 stall cycles
        do_reset();
        for (int i = 0; i < 20; i++) begin
            drv(1, 1, 0, 10'(300 + i), 32'(i), 1, 1, 0, 10'(400 + i), 32'(i));
            tick();
        end
        idle();
        chk("s6_grants", 64'(grant_cnt0) + 64'(grant_cnt1), 20);
        chk("s6_g0", grant_cnt0, 12);
        chk("s6_stall", stall_cnt, 20);
        tick();
`endif

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
